// File: rtl/vc_scheduler.sv
// Two-VC to two-destination scheduler: VC0 priority with a starvation escape
// for VC1, back-pressure gating, bit-4 routing and per-destination push counts.
module vc_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       RESET_L,
  input  logic       VC0_EMPTY,
  input  logic       VC1_EMPTY,
  input  logic       VC0_VALID,
  input  logic       VC1_VALID,
  input  logic [5:0] DATA_OUT_VC0,
  input  logic [5:0] DATA_OUT_VC1,
  input  logic       D0_PAUSE,
  input  logic       D1_PAUSE,
  output logic       POP_VC0,
  output logic       POP_VC1,
  output logic       PUSH_D0,
  output logic       PUSH_D1,
  output logic [5:0] data_to_D0,
  output logic [5:0] data_to_D1,
  output logic [7:0] CNT_D0,
  output logic [7:0] CNT_D1,
  output logic       SCHED_ERR
);

  typedef enum logic [1:0] {IDLE, GNT_VC0, GNT_VC1} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state_d, state_q;
  logic [2:0] starve_d, starve_q;
  logic       run_d, run_q;
  logic       push_d0_d, push_d0_q, push_d1_d, push_d1_q;
  logic [5:0] data_d0_d, data_d0_q, data_d1_d, data_d1_q;
  logic [7:0] cnt_d0_d, cnt_d0_q, cnt_d1_d, cnt_d1_q;
  logic       err_d, err_q;
  logic       route_vld;
  logic [5:0] route_word;

  // state_d is this cycle's grant; state_q remembers last cycle's grant so an
  // arriving VALID can be matched to the pop that should have caused it.
  // run_q holds off pops until the first clock edge after reset release.
  always_comb begin
    run_d   = 1'b1;
    state_d = IDLE;
    if (run_q && !(D0_PAUSE || D1_PAUSE)) begin
      if (!VC1_EMPTY && (VC0_EMPTY || starve_q == LIMIT)) begin
        state_d = GNT_VC1;
      end else if (!VC0_EMPTY) begin
        state_d = GNT_VC0;
      end
    end

    if (VC1_EMPTY || state_d == GNT_VC1) begin
      starve_d = '0;
    end else if (state_d == GNT_VC0 && starve_q != LIMIT) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // VC0 wins when both VALIDs collide; the VC1 word is dropped and flagged.
  always_comb begin
    route_vld  = VC0_VALID || VC1_VALID;
    route_word = VC0_VALID ? DATA_OUT_VC0 : DATA_OUT_VC1;
    push_d0_d  = route_vld && !route_word[4];
    push_d1_d  = route_vld && route_word[4];
    data_d0_d  = push_d0_d ? route_word : data_d0_q;
    data_d1_d  = push_d1_d ? route_word : data_d1_q;
    cnt_d0_d   = cnt_d0_q + {7'd0, push_d0_q};
    cnt_d1_d   = cnt_d1_q + {7'd0, push_d1_q};
    err_d      = err_q
               || (VC0_VALID && VC1_VALID)
               || (VC0_VALID && state_q != GNT_VC0)
               || (VC1_VALID && state_q != GNT_VC1);
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      run_q     <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_d0_q <= '0;
      data_d1_q <= '0;
      cnt_d0_q  <= '0;
      cnt_d1_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      run_q     <= run_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_d0_q <= data_d0_d;
      data_d1_q <= data_d1_d;
      cnt_d0_q  <= cnt_d0_d;
      cnt_d1_q  <= cnt_d1_d;
      err_q     <= err_d;
    end
  end

  assign POP_VC0    = (state_d == GNT_VC0);
  assign POP_VC1    = (state_d == GNT_VC1);
  assign PUSH_D0    = push_d0_q;
  assign PUSH_D1    = push_d1_q;
  assign data_to_D0 = data_d0_q;
  assign data_to_D1 = data_d1_q;
  assign CNT_D0     = cnt_d0_q;
  assign CNT_D1     = cnt_d1_q;
  assign SCHED_ERR  = err_q;

endmodule

// File: doc/vc_scheduler.md
VC_SCHEDULER -- requirements
Module: vc_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive VC0 grants after which VC1 is granted once if it is non-empty.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports VC0_EMPTY and VC1_EMPTY, input, 1 bit each: the VC FIFO empty flags.
REQ-005 SHALL have ports VC0_VALID and VC1_VALID, input, 1 bit each: the VC FIFO read-data-valid flags, arriving one cycle after a pop.
REQ-006 SHALL have ports DATA_OUT_VC0 and DATA_OUT_VC1, input, 6 bits each: the VC FIFO read data; bit 4 is the destination ID.
REQ-007 SHALL have ports D0_PAUSE and D1_PAUSE, input, 1 bit each: the destination FIFO almost-full back-pressure flags.
REQ-008 SHALL have ports POP_VC0 and POP_VC1, output, 1 bit each: combinational pop requests to the VC FIFOs.
REQ-009 SHALL have ports PUSH_D0 and PUSH_D1, output, 1 bit each: registered push strobes to the destination FIFOs.
REQ-010 SHALL have ports data_to_D0 and data_to_D1, output, 6 bits each: registered write data to the destination FIFOs.
REQ-011 SHALL have ports CNT_D0 and CNT_D1, output, 8 bits each: counts of words pushed to each destination.
REQ-012 SHALL have port SCHED_ERR, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 SHALL assert at most one of POP_VC0 and POP_VC1 in any cycle.
REQ-014 SHALL assert no pop in a cycle where D0_PAUSE or D1_PAUSE is high, because the destination is unknown before the pop.
REQ-015 SHALL implement the FSM states IDLE, GNT_VC0 and GNT_VC1, where the state is the grant issued in the current cycle.
- IDLE: both VC FIFOs empty or paused.
- In GNT_VC0 or GNT_VC1, POP_VCx = 1 for the granted FIFO.
REQ-016 SHALL grant VC0 whenever VC0 is non-empty and not paused, except under the starvation rule in REQ-017.
REQ-017 SHALL grant VC1 for exactly one cycle when a 3-bit starve counter equals STARVE_LIMIT and VC1 is non-empty.
- The starve counter increments on each VC0 grant while VC1 is non-empty.
- It clears on any VC1 grant or when VC1 is empty.
- It saturates at STARVE_LIMIT.
REQ-018 SHALL grant VC1 when VC0 is empty, VC1 is non-empty, and there is no pause.
REQ-019 SHALL route a word presented with VCx_VALID = 1 by bit 4: 0 selects D0 and 1 selects D1.
- The word is registered into data_to_Dy, and PUSH_Dy is asserted the following cycle.
- Latency from pop to push is 2 cycles.
REQ-020 SHALL hold PUSH_D0 and PUSH_D1 low in any cycle with no routed word, and SHALL hold data_to_D0 and data_to_D1 at their last value.
REQ-021 SHALL allow up to 2 words in flight after a pause rises; no push is suppressed or dropped once a pop has been issued.
REQ-022 SHALL increment CNT_Dy by 1 on each PUSH_Dy, and SHALL wrap from 255 to 0 without a flag.
REQ-023 SHALL set SCHED_ERR in either of these cases:
- VC0_VALID and VC1_VALID are both high in the same cycle;
- a VALID arrives without a pop to that FIFO in the previous cycle.
REQ-024 SHALL clear SCHED_ERR only by reset.
REQ-025 SHALL, when both VALIDs are high, route the VC0 word and discard the VC1 word.
REQ-026 SHALL ignore a pop request against an empty FIFO; the condition cannot occur, because pops are gated by the EMPTY flags.

Reset
REQ-027 SHALL, while RESET_L = 0, immediately force:
- FSM = IDLE;
- starve counter = 0;
- POP_VC0 = POP_VC1 = 0;
- PUSH_D0 = PUSH_D1 = 0;
- data_to_D0 = data_to_D1 = 0;
- CNT_D0 = CNT_D1 = 0;
- SCHED_ERR = 0.
REQ-028 SHALL discard any in-flight word when reset is asserted mid-operation, and SHALL produce no push after reset is released until a new pop plus 2 cycles.
REQ-029 SHALL issue its first pop no earlier than the first rising edge after RESET_L goes high.

Verification
REQ-030 Single word: VC0 holds 0x05 → POP_VC0 at cycle N; PUSH_D0 = 1 with data_to_D0 = 0x05 at N+2; CNT_D0 = 1.
REQ-031 Routing: VC1 holds 0x31 (bit 4 = 1) and VC0 is empty → POP_VC1, then PUSH_D1 with data 0x31; CNT_D1 = 1; PUSH_D0 = 0.
REQ-032 Starvation: both VCs hold 10 words with STARVE_LIMIT = 4 → grant order VC0×4, VC1, VC0×4, VC1, … until VC0 is empty.
REQ-033 Pause: D1_PAUSE rises in the cycle after a pop → no new pop while it stays high; the in-flight word is still pushed; pops resume the cycle after the pause falls.
REQ-034 Error: VC0_VALID and VC1_VALID are driven high together with no preceding pop → SCHED_ERR = 1 and stays 1 until RESET_L = 0.
REQ-035 Reset and wrap:
- 256 pushes to D0 → CNT_D0 = 0.
- RESET_L pulsed low mid-stream → all outputs are 0 within the same cycle and no push occurs for 2 cycles after release.
